// File: rtl/eth_tx_arb_if.sv
// Bus bundle for the Ethernet TX arbiter: two upstream byte-stream requesters
// plus the single MII transmit byte stream and the latched frame header fields.
interface eth_tx_arb_if;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [1:0]  req_sop;
  logic [1:0]  req_eop;
  logic [15:0] req_byte;
  logic [95:0] req_dst_mac;
  logic [31:0] req_pkt_type;
  logic        eth_vld;
  logic        eth_rdy;
  logic        eth_sop;
  logic        eth_eop;
  logic [7:0]  eth_tx_byte;
  logic [47:0] dst_mac;
  logic [15:0] pkt_type;

  modport master (
    output req_vld, req_sop, req_eop, req_byte, req_dst_mac, req_pkt_type, eth_rdy,
    input  req_rdy, eth_vld, eth_sop, eth_eop, eth_tx_byte, dst_mac, pkt_type
  );

  modport slave (
    input  req_vld, req_sop, req_eop, req_byte, req_dst_mac, req_pkt_type, eth_rdy,
    output req_rdy, eth_vld, eth_sop, eth_eop, eth_tx_byte, dst_mac, pkt_type
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter sharing one MII TX byte stream between two
// frame sources, with payload-length truncation and a programmable inter-frame gap.
module eth_tx_arb #(
  parameter int P_MAX_BYTES  = 150,
  parameter int P_GAP_CYCLES = 4
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  eth_tx_arb_if.slave bus,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        trunc_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [10:0] LP_LAST_IDX = 11'(P_MAX_BYTES - 1);
  localparam logic [7:0]  LP_GAP      = 8'(P_GAP_CYCLES);

  state_t      state_r, state_nxt_s;
  logic [1:0]  grant_r, grant_nxt_s;
  logic        rr_last_r, rr_last_nxt_s;
  logic [10:0] byte_cnt_r, byte_cnt_nxt_s;
  logic [7:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic        trunc_err_r, trunc_err_nxt_s;
  logic [47:0] dst_mac_r, dst_mac_nxt_s;
  logic [15:0] pkt_type_r, pkt_type_nxt_s;

  logic        g_s;
  logic        g_vld_s;
  logic        g_eop_s;
  logic [7:0]  g_byte_s;
  logic        at_max_s;
  logic [1:0]  cand_s;
  logic        win_s;
  logic [1:0]  req_rdy_s;
  logic        eth_vld_s;
  logic        eth_sop_s;
  logic        eth_eop_s;
  logic [7:0]  eth_byte_s;

  // Granted requester's view; grant is one-hot so bit 1 is the owner index.
  assign g_s      = grant_r[1];
  assign g_vld_s  = bus.req_vld[g_s];
  assign g_eop_s  = bus.req_eop[g_s];
  assign g_byte_s = g_s ? bus.req_byte[15:8] : bus.req_byte[7:0];
  assign at_max_s = (byte_cnt_r == LP_LAST_IDX);
  assign cand_s   = bus.req_vld & bus.req_sop;

  // Round-robin pick among sop-valid candidates; ties go to the non-last winner.
  always_comb begin
    win_s = 1'b0;
    case (cand_s)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~rr_last_r;
      default: win_s = 1'b0;
    endcase
  end

  // Next-state and handshake outputs for the frame FSM.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    rr_last_nxt_s   = rr_last_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    trunc_err_nxt_s = 1'b0;
    dst_mac_nxt_s   = dst_mac_r;
    pkt_type_nxt_s  = pkt_type_r;
    req_rdy_s       = 2'b00;
    eth_vld_s       = 1'b0;
    eth_sop_s       = 1'b0;
    eth_eop_s       = 1'b0;
    eth_byte_s      = 8'h00;
    case (state_r)
      S_IDLE: begin
        if (cand_s != 2'b00) begin
          grant_nxt_s    = win_s ? 2'b10 : 2'b01;
          rr_last_nxt_s  = win_s;
          dst_mac_nxt_s  = win_s ? bus.req_dst_mac[95:48] : bus.req_dst_mac[47:0];
          pkt_type_nxt_s = win_s ? bus.req_pkt_type[31:16] : bus.req_pkt_type[15:0];
          byte_cnt_nxt_s = 11'd0;
          state_nxt_s    = S_FWD;
        end else begin
          grant_nxt_s = 2'b00;
        end
      end
      S_FWD: begin
        eth_vld_s  = g_vld_s;
        req_rdy_s  = g_s ? {bus.eth_rdy, 1'b0} : {1'b0, bus.eth_rdy};
        eth_byte_s = g_byte_s;
        eth_sop_s  = g_vld_s & (byte_cnt_r == 11'd0);
        eth_eop_s  = g_vld_s & (g_eop_s | at_max_s);
        if (g_vld_s & bus.eth_rdy) begin
          byte_cnt_nxt_s = byte_cnt_r + 11'd1;
          // A real eop on the limit beat wins over truncation.
          if (g_eop_s) begin
            state_nxt_s   = S_GAP;
            gap_cnt_nxt_s = LP_GAP;
          end else if (at_max_s) begin
            trunc_err_nxt_s = 1'b1;
            state_nxt_s     = S_DRAIN;
          end else begin
            state_nxt_s = S_FWD;
          end
        end else begin
          state_nxt_s = S_FWD;
        end
      end
      S_DRAIN: begin
        req_rdy_s = g_s ? 2'b10 : 2'b01;
        if (g_vld_s & g_eop_s) begin
          state_nxt_s   = S_GAP;
          gap_cnt_nxt_s = LP_GAP;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == 8'd0) begin
          state_nxt_s = S_IDLE;
          grant_nxt_s = 2'b00;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        grant_nxt_s = 2'b00;
      end
    endcase
  end

  // State and frame-context registers with synchronous active-low reset.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      grant_r     <= 2'b00;
      rr_last_r   <= 1'b1;
      byte_cnt_r  <= 11'd0;
      gap_cnt_r   <= 8'd0;
      trunc_err_r <= 1'b0;
      dst_mac_r   <= 48'h0;
      pkt_type_r  <= 16'h0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      rr_last_r   <= rr_last_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
      trunc_err_r <= trunc_err_nxt_s;
      dst_mac_r   <= dst_mac_nxt_s;
      pkt_type_r  <= pkt_type_nxt_s;
    end
  end

  assign bus.req_rdy     = req_rdy_s;
  assign bus.eth_vld     = eth_vld_s;
  assign bus.eth_sop     = eth_sop_s;
  assign bus.eth_eop     = eth_eop_s;
  assign bus.eth_tx_byte = eth_byte_s;
  assign bus.dst_mac     = dst_mac_r;
  assign bus.pkt_type    = pkt_type_r;
  assign grant           = grant_r;
  assign busy            = (state_r != S_IDLE);
  assign trunc_err       = trunc_err_r;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: three instances (default, max=4/gap=0, gap=10)
// share one stimulus; the selected instance drives the handshake and is checked.
module tb_eth_tx_arb;

  typedef struct packed {
    logic [1:0]  req_rdy;
    logic        eth_vld;
    logic        eth_sop;
    logic        eth_eop;
    logic [7:0]  eth_tx_byte;
    logic [47:0] dst_mac;
    logic [15:0] pkt_type;
    logic [1:0]  grant;
    logic        busy;
    logic        trunc_err;
  } obs_t;

  typedef struct packed {
    logic [7:0]  b;
    logic        sop;
    logic        eop;
    logic [1:0]  g;
    logic [47:0] mac;
  } beat_t;

  logic        tx_clk;
  logic        rst_n;
  logic [1:0]  req_vld, req_sop, req_eop;
  logic [15:0] req_byte;
  logic [95:0] req_dst_mac;
  logic [31:0] req_pkt_type;
  logic        eth_rdy;
  logic        eth_rdy_lvl;
  logic        tog_en;
  logic [3:0]  tog_pat;
  logic [1:0]  tog_ph = 2'd0;
  logic [1:0]  sel;
  logic        mir_en;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  obs_t  obs_a [3];
  obs_t  obs;
  beat_t log_q[$];
  int    eop_edges[$];
  int    grant_rises[$];
  int    busy_falls[$];
  int    trunc_cnt = 0;
  int    drain_cnt = 0;
  int    lb, eb, gb, bb, tcb, dcb;

  assign eth_rdy = tog_en ? tog_pat[tog_ph] : eth_rdy_lvl;
  assign obs     = obs_a[sel];

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [1:0] grant_w;
    logic       busy_w;
    logic       trunc_w;
    eth_tx_arb_if arb_bus ();
    assign arb_bus.req_vld      = req_vld;
    assign arb_bus.req_sop      = req_sop;
    assign arb_bus.req_eop      = req_eop;
    assign arb_bus.req_byte     = req_byte;
    assign arb_bus.req_dst_mac  = req_dst_mac;
    assign arb_bus.req_pkt_type = req_pkt_type;
    assign arb_bus.eth_rdy      = eth_rdy;
    assign obs_a[i] = {arb_bus.req_rdy, arb_bus.eth_vld, arb_bus.eth_sop, arb_bus.eth_eop,
                       arb_bus.eth_tx_byte, arb_bus.dst_mac, arb_bus.pkt_type,
                       grant_w, busy_w, trunc_w};
    eth_tx_arb #(
      .P_MAX_BYTES  ((i == 1) ? 4 : 150),
      .P_GAP_CYCLES ((i == 0) ? 4 : ((i == 1) ? 0 : 10))
    ) u_dut (
      .tx_clk    (tx_clk),
      .rst_n     (rst_n),
      .bus       (arb_bus),
      .grant     (grant_w),
      .busy      (busy_w),
      .trunc_err (trunc_w)
    );
  end

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  always @(posedge tx_clk) begin
    cyc    <= cyc + 1;
    tog_ph <= tog_ph + 2'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: logs accepted beats and event times, counts truncation pulses and drained beats.
  initial begin
    logic [1:0] prev_g;
    logic       prev_b;
    prev_g = 2'b00;
    prev_b = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (obs.eth_vld && eth_rdy) begin
        log_q.push_back({obs.eth_tx_byte, obs.eth_sop, obs.eth_eop, obs.grant, obs.dst_mac});
        if (obs.eth_eop) eop_edges.push_back(cyc + 1);
      end
      if (obs.grant != 2'b00 && prev_g == 2'b00) grant_rises.push_back(cyc);
      if (!obs.busy && prev_b) busy_falls.push_back(cyc);
      if (obs.trunc_err) trunc_cnt++;
      if (((obs.req_rdy & req_vld) != 2'b00) && !obs.eth_vld) drain_cnt++;
      if (mir_en) begin
        chk("rdy0_low", {63'd0, obs.req_rdy[0]}, 64'd0);
        if (obs.eth_vld) chk("rdy1_mirror", {63'd0, obs.req_rdy[1]}, {63'd0, eth_rdy});
      end
      prev_g = obs.grant;
      prev_b = obs.busy;
    end
  end

  task automatic snap();
    lb  = log_q.size();
    eb  = eop_edges.size();
    gb  = grant_rises.size();
    bb  = busy_falls.size();
    tcb = trunc_cnt;
    dcb = drain_cnt;
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst_n       = 1'b0;
    req_vld     = 2'b00;
    req_sop     = 2'b00;
    req_eop     = 2'b00;
    eth_rdy_lvl = 1'b1;
    tog_en      = 1'b0;
    mir_en      = 1'b0;
    sel         = s;
    repeat (2) @(posedge tx_clk);
    #1;
    rst_n = 1'b1;
    snap();
  endtask

  task automatic send_frame(input int n, input int len, input logic [7:0] b0, input logic [7:0] step,
                            input logic [47:0] mac, input logic [15:0] typ, input int stop_after);
    int acc_cnt;
    acc_cnt = 0;
    for (int i = 0; i < len && acc_cnt < stop_after; i++) begin
      logic acc;
      int   wt;
      req_vld[n] = 1'b1;
      req_sop[n] = (i == 0);
      req_eop[n] = (i == len - 1);
      req_byte[8*n +: 8]      = b0 + 8'(i) * step;
      req_dst_mac[48*n +: 48] = mac;
      req_pkt_type[16*n +: 16] = typ;
      acc = 1'b0;
      wt  = 0;
      while (!acc && wt < 300) begin
        @(negedge tx_clk);
        acc = obs.req_rdy[n];
        @(posedge tx_clk);
        #1;
        wt++;
      end
      chk("beat_accepted", {63'd0, acc}, 64'd1);
      acc_cnt++;
    end
    req_vld[n] = 1'b0;
    req_sop[n] = 1'b0;
    req_eop[n] = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [7:0] b, input logic sop,
                            input logic eop, input logic [1:0] g);
    beat_t bt;
    bt = (idx < log_q.size()) ? log_q[idx] : '0;
    chk({tag, "_byte"}, {56'd0, bt.b}, {56'd0, b});
    chk({tag, "_sop"}, {63'd0, bt.sop}, {63'd0, sop});
    chk({tag, "_eop"}, {63'd0, bt.eop}, {63'd0, eop});
    chk({tag, "_grant"}, {62'd0, bt.g}, {62'd0, g});
  endtask

  initial begin
    int d;
    logic [7:0] t1_bytes [3];
    req_byte     = 16'h0;
    req_dst_mac  = 96'h0;
    req_pkt_type = 32'h0;
    t1_bytes[0] = 8'h11;
    t1_bytes[1] = 8'h22;
    t1_bytes[2] = 8'h33;
    tog_pat = 4'b1001;

    // Reset state
    do_reset(2'd0);
    @(negedge tx_clk);
    chk("rst_grant", {62'd0, obs.grant}, 64'd0);
    chk("rst_busy", {63'd0, obs.busy}, 64'd0);
    chk("rst_eth_vld", {63'd0, obs.eth_vld}, 64'd0);
    chk("rst_req_rdy", {62'd0, obs.req_rdy}, 64'd0);
    chk("rst_dst_mac", {16'd0, obs.dst_mac}, 64'd0);
    chk("rst_trunc", {63'd0, obs.trunc_err}, 64'd0);

    // Single 3-byte frame from req0
    send_frame(0, 3, 8'h11, 8'h11, 48'h0A0B0C0D0E0F, 16'h0806, 3);
    req_dst_mac  = 96'h0;
    req_pkt_type = 32'h0;
    #1;
    chk("t1_dst_mac_held", {16'd0, obs.dst_mac}, 64'h0A0B0C0D0E0F);
    chk("t1_pkt_type_held", {48'd0, obs.pkt_type}, 64'h0806);
    chk("t1_grant_held", {62'd0, obs.grant}, 64'd1);
    repeat (10) @(posedge tx_clk);
    chk("t1_nbeats", 64'(log_q.size() - lb), 64'd3);
    for (int i = 0; i < 3; i++) check_beat("t1", lb + i, t1_bytes[i], (i == 0), (i == 2), 2'b01);
    d = (busy_falls.size() > bb && eop_edges.size() > eb) ? busy_falls[bb] - eop_edges[eb] : -1;
    chk("t1_busy_drop", 64'(d), 64'd5);

    // Both requesters, 4 back-to-back 2-byte frames each: strict alternation
    do_reset(2'd0);
    fork
      for (int m = 0; m < 4; m++) send_frame(0, 2, 8'hA0 + 8'(2*m), 8'd1, 48'h00AA00AA00AA, 16'h0806, 2);
      for (int m = 0; m < 4; m++) send_frame(1, 2, 8'hB0 + 8'(2*m), 8'd1, 48'h00BB00BB00BB, 16'h0800, 2);
    join
    repeat (10) @(posedge tx_clk);
    chk("t2_nbeats", 64'(log_q.size() - lb), 64'd16);
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < 2; j++) begin
        check_beat("t2", lb + 2*f + j, 8'hA0 + 8'(16*(f % 2)) + 8'(2*(f/2)) + 8'(j),
                   (j == 0), (j == 1), (f % 2 == 0) ? 2'b01 : 2'b10);
      end
    end

    // req1 5-byte frame with eth_rdy pattern 1,0,0,1
    do_reset(2'd0);
    tog_en = 1'b1;
    mir_en = 1'b1;
    send_frame(1, 5, 8'h51, 8'd1, 48'h123456789ABC, 16'h0800, 5);
    mir_en = 1'b0;
    tog_en = 1'b0;
    repeat (8) @(posedge tx_clk);
    chk("t3_nbeats", 64'(log_q.size() - lb), 64'd5);
    for (int i = 0; i < 5; i++) check_beat("t3", lb + i, 8'h51 + 8'(i), (i == 0), (i == 4), 2'b10);

    // Truncation at 4 bytes on the max=4/gap=0 instance
    do_reset(2'd1);
    send_frame(0, 7, 8'h01, 8'd1, 48'h0000DEADBEEF, 16'h0800, 7);
    repeat (8) @(posedge tx_clk);
    chk("t4_nbeats", 64'(log_q.size() - lb), 64'd4);
    for (int i = 0; i < 4; i++) check_beat("t4", lb + i, 8'h01 + 8'(i), (i == 0), (i == 3), 2'b01);
    chk("t4_trunc_pulses", 64'(trunc_cnt - tcb), 64'd1);
    chk("t4_drained", 64'(drain_cnt - dcb), 64'd3);
    chk("t4_idle_after", {63'd0, obs.busy}, 64'd0);

    // Gap timing: gap=0 (instance 1) and gap=10 (instance 2), req1 pending during gap
    for (int k = 1; k < 3; k++) begin
      do_reset(2'(k));
      fork
        send_frame(0, 2, 8'h61, 8'd1, 48'h111111111111, 16'h0806, 2);
        begin
          repeat (3) @(posedge tx_clk);
          #1;
          send_frame(1, 2, 8'h71, 8'd1, 48'h222222222222, 16'h0800, 2);
        end
      join
      repeat (15) @(posedge tx_clk);
      d = (grant_rises.size() > gb + 1 && eop_edges.size() > eb) ? grant_rises[gb + 1] - eop_edges[eb] : -1;
      chk((k == 1) ? "t5_gap0_regrant" : "t5_gap10_regrant", 64'(d), (k == 1) ? 64'd2 : 64'd12);
      check_beat("t5_second", lb + 2, 8'h71, 1'b1, 1'b0, 2'b10);
    end

    // Reset mid-frame after 2nd byte, then fresh req1 frame
    do_reset(2'd0);
    send_frame(0, 5, 8'h81, 8'd1, 48'h0A0B0C0D0E0F, 16'h0806, 2);
    rst_n = 1'b0;
    @(posedge tx_clk);
    #1;
    rst_n = 1'b1;
    @(negedge tx_clk);
    chk("t6_grant", {62'd0, obs.grant}, 64'd0);
    chk("t6_busy", {63'd0, obs.busy}, 64'd0);
    chk("t6_eth_vld", {63'd0, obs.eth_vld}, 64'd0);
    chk("t6_eth_eop", {63'd0, obs.eth_eop}, 64'd0);
    chk("t6_req_rdy", {62'd0, obs.req_rdy}, 64'd0);
    chk("t6_dst_mac", {16'd0, obs.dst_mac}, 64'd0);
    chk("t6_pkt_type", {48'd0, obs.pkt_type}, 64'd0);
    chk("t6_nbeats", 64'(log_q.size() - lb), 64'd2);
    check_beat("t6_b1", lb + 1, 8'h82, 1'b0, 1'b0, 2'b01);
    @(posedge tx_clk);
    #1;
    snap();
    send_frame(1, 2, 8'h91, 8'd1, 48'h333333333333, 16'h0800, 2);
    repeat (8) @(posedge tx_clk);
    check_beat("t6_req1", lb, 8'h91, 1'b1, 1'b0, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single MII transmit byte-stream input between two upstream frame sources (e.g. ARP responder = requester 0, IP/UDP sender = requester 1).
- Holds a grant for a whole frame and latches that frame's dst_mac/pkt_type.
- Enforces a maximum payload length by truncating overlong frames.
- Inserts a programmable idle gap between frames before re-arbitrating.

Parameters:
- P_MAX_BYTES, 150, maximum payload bytes forwarded per frame (1..1023).
- P_GAP_CYCLES, 4, idle tx_clk cycles after a frame's last accepted beat before the next grant (0..255).

Ports:
- tx_clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_vld  in  2  per-requester byte valid
- req_rdy  out  2  per-requester byte ready
- req_sop  in  2  per-requester first-byte flag
- req_eop  in  2  per-requester last-byte flag
- req_byte  in  16  byte of req n at [8n+7:8n]
- req_dst_mac  in  96  dst MAC of req n at [48n+47:48n]; stable while req_vld&req_sop
- req_pkt_type  in  32  EtherType of req n at [16n+15:16n]; stable while req_vld&req_sop
- eth_vld  out  1  byte valid to MAC TX
- eth_rdy  in  1  byte ready from MAC TX
- eth_sop  out  1  first beat of frame
- eth_eop  out  1  last beat of frame
- eth_tx_byte  out  8  payload byte
- dst_mac  out  48  latched dst MAC of current frame
- pkt_type  out  16  latched EtherType of current frame
- grant  out  2  one-hot current owner, 0 when none
- busy  out  1  state != S_IDLE
- trunc_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset: rst_n is synchronous and active-low; tx_clk is the clock. Reset values:
  - state=S_IDLE, grant=0, rr_last=1 (requester 0 wins the first tie), byte_cnt=0, gap_cnt=0, trunc_err=0, dst_mac=0, pkt_type=0.
  - All outputs are 0, including req_rdy and eth_vld.
  - Reset mid-frame aborts the frame immediately; no eop is emitted.
- States: S_IDLE, S_FWD, S_DRAIN, S_GAP (2-bit encoding).
- S_IDLE arbitration:
  - cand[n] = req_vld[n] & req_sop[n].
  - One candidate: grant it. Two candidates: grant ~rr_last.
  - Registered transition: grant is set, dst_mac/pkt_type are latched from the winner, rr_last is set to the winner, byte_cnt=0, state -> S_FWD. First forwarding beat is possible on the next cycle.
  - req_rdy=0 in S_IDLE, so the sop beat is held by the requester, not consumed.
  - req_vld without req_sop in S_IDLE is never granted (protocol violation; the requester stalls).
- S_FWD (g = granted index), combinational pass-through:
  - eth_vld=req_vld[g]; req_rdy[g]=eth_rdy; req_rdy for the other requester is 0.
  - eth_tx_byte=req_byte[g]; eth_sop=eth_vld&(byte_cnt==0).
  - eth_eop=eth_vld&(req_eop[g] | byte_cnt==P_MAX_BYTES-1).
  - A beat is accepted when eth_vld&eth_rdy; byte_cnt increments (11-bit, no wrap within legal range).
  - Accepted beat with req_eop[g]: state -> S_GAP, gap_cnt=P_GAP_CYCLES.
  - Accepted beat with byte_cnt==P_MAX_BYTES-1 and !req_eop[g]: forwarded with eth_eop forced to 1, trunc_err pulses next cycle, state -> S_DRAIN.
  - Both conditions on the same beat: treated as a normal eop, no trunc_err.
- S_DRAIN:
  - eth_vld=0; req_rdy[g]=1. Requester g's beats are discarded until its req_vld&req_eop beat, then -> S_GAP with gap_cnt=P_GAP_CYCLES.
- S_GAP:
  - All ready/valid outputs are 0.
  - gap_cnt==0: -> S_IDLE, grant=0. Otherwise gap_cnt decrements.
  - With P_GAP_CYCLES=0 this stays one cycle in S_GAP, so the next grant register is set at the earliest 2 cycles after the eop acceptance.
- Held stable for the whole frame (S_FWD through S_GAP): dst_mac, pkt_type, grant.
- Fairness: with both requesters continuously pending, grants strictly alternate.
- eth_rdy low stalls forwarding indefinitely with no state change; byte and flags track the requester, which must hold them per ready/valid.

Test Plan:
- Reset, req0 sends 3 bytes 0x11,0x22,0x33 (eop on 0x33), dst_mac 0x0A0B0C0D0E0F, eth_rdy=1 -> eth_sop on 0x11 only, eth_eop on 0x33, dst_mac latched, grant=01, busy drops P_GAP_CYCLES+1 cycles after eop.
- Both requesters assert sop-valid in the same cycle, each sending 2-byte frames 4 times back-to-back -> grant order 0,1,0,1,0,1,0,1; no byte interleaving.
- req1 frame of 5 bytes with eth_rdy toggling 1,0,0,1 pattern -> all 5 bytes emitted in order, each exactly once; req_rdy[1] mirrors eth_rdy; req_rdy[0]=0 throughout.
- P_MAX_BYTES=4, req0 sends 7 bytes 0x01..0x07 -> bytes 0x01..0x04 forwarded, eth_eop on 0x04, trunc_err one pulse, 0x05..0x07 consumed with eth_vld=0, then gap.
- P_GAP_CYCLES=0 and P_GAP_CYCLES=10 with req1 pending during gap -> next grant no earlier than 2 / 12 cycles after the prior eop acceptance.
- rst_n low for 1 cycle after the 2nd byte of a req0 frame -> next cycle: all outputs 0, state S_IDLE; a fresh req1 sop frame is granted first (rr_last reset to 1).
